// File: rtl/adder_pkg.sv
// Shared types and the golden add/subtract model for the pipelined adder datapath.
package adder_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  localparam int MAX_WIDTH  = 32;
  localparam int MAX_STAGES = 8;

  typedef struct packed {
    logic               ovf;
    logic [MAX_WIDTH:0] sum;
  } ref_result_t;

  // Bit-serial ripple model over the low `width` bits; the sum field holds {carry, result}.
  function automatic ref_result_t ref_addsub(input logic [MAX_WIDTH-1:0] a,
                                             input logic [MAX_WIDTH-1:0] b,
                                             input op_e                  op,
                                             input int                   width);
    ref_result_t        r;
    logic               c;
    logic               cmsb;
    logic               bb;
    logic [MAX_WIDTH:0] cbit;
    r    = '0;
    c    = (op == OP_SUB);
    cmsb = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        bb       = b[i] ^ (op == OP_SUB);
        r.sum[i] = a[i] ^ bb ^ c;
        if (i == width - 1) cmsb = c;
        c = (a[i] & bb) | (a[i] & c) | (bb & c);
      end
    end
    cbit    = '0;
    cbit[0] = c;
    r.sum   = r.sum | (cbit << width);
    r.ovf   = c ^ cmsb;
    return r;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry-chain slice: SW-bit add with carry-in, carry-out and carry into the slice MSB.
module addsub_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  logic [SW:0] total;

  // The MSB sum bit is a^b^cin_msb, so the carry into it falls out of the XOR.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    sum   = total[SW-1:0];
    cout  = total[SW];
    cmsb  = a[SW-1] ^ b[SW-1] ^ total[SW-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: the carry chain is cut into STAGES slices, one per register stage,
// with a bubble-collapsing valid/ready chain and a tag riding alongside each operation.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0] valid_q, valid_d, load_en;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  a_src   [STAGES];
  logic [WIDTH-1:0]  b_src   [STAGES];
  logic [WIDTH-1:0]  res_src [STAGES];
  logic [TAG_W-1:0]  tag_src [STAGES];
  logic [STAGES-1:0] cin_src, v_src;
  logic [SW-1:0]     slice_sum  [STAGES];
  logic              slice_cout [STAGES];
  logic              slice_cmsb [STAGES];

  // B is inverted once on entry, so the op itself only lives on as the stage-0 carry-in.
  always_comb begin
    a_src[0]   = in_a;
    b_src[0]   = (op_e'(in_op) == OP_SUB) ? ~in_b : in_b;
    res_src[0] = '0;
    tag_src[0] = in_tag;
    cin_src[0] = in_op;
    v_src[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      res_src[k] = res_q[k-1];
      tag_src[k] = tag_q[k-1];
      cin_src[k] = carry_q[k-1];
      v_src[k]   = valid_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    addsub_slice #(.SW(SW)) u_slice (
      .a    (a_src[k][k*SW +: SW]),
      .b    (b_src[k][k*SW +: SW]),
      .cin  (cin_src[k]),
      .sum  (slice_sum[k]),
      .cout (slice_cout[k]),
      .cmsb (slice_cmsb[k])
    );
  end

  // A stage can load if it is empty or everything between it and the output can move.
  always_comb begin
    logic can_take;
    can_take = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      can_take   = can_take || !valid_q[k];
      load_en[k] = can_take;
    end
  end

  assign in_ready = load_en[0];

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    tag_d   = tag_q;
    ovf_d   = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      if (load_en[k]) begin
        valid_d[k] = v_src[k];
        if (v_src[k]) begin
          a_d[k]                 = a_src[k];
          b_d[k]                 = b_src[k];
          tag_d[k]               = tag_src[k];
          res_d[k]               = res_src[k];
          res_d[k][k*SW +: SW]   = slice_sum[k];
          carry_d[k]             = slice_cout[k];
        end
      end
    end
    if (load_en[STAGES-1] && v_src[STAGES-1]) begin
      ovf_d = slice_cout[STAGES-1] ^ slice_cmsb[STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = {carry_q[STAGES-1], res_q[STAGES-1]};
  assign out_ovf   = ovf_q;
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined add/subtract unit with a valid/ready handshake on both sides. It splits the carry chain into `STAGES` equal slices, one per pipeline register, and sustains one operation per cycle under backpressure. A user tag travels alongside each operation. It is the next-generation arithmetic leaf for the adder datapath and drops in where a single-cycle `valid`-only adder cannot meet timing or cannot be stalled.

## Interface
Parameters:
- `WIDTH`, 16: operand width in bits; must be divisible by `STAGES`.
- `STAGES`, 4: pipeline depth and carry-chain slice count; legal range 1..8.
- `TAG_W`, 4: width of the pass-through tag; legal range ≥1.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation offered.
- `in_ready` output 1: unit can accept this cycle.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B.
- `in_op` input 1: `OP_ADD`=0, `OP_SUB`=1.
- `in_tag` input TAG_W: user tag, returned unchanged.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream accepts.
- `out_sum` output WIDTH+1: `{carry_out, result}`.
- `out_ovf` output 1: two's-complement signed overflow.
- `out_tag` output TAG_W: tag of this result.

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready`.
- Arithmetic: compute `in_a + (in_op ? ~in_b : in_b) + in_op` at WIDTH+1 bits.
  - `out_sum[WIDTH]` is the final carry. For SUB, 1 means no borrow.
  - `out_ovf` = carry into MSB XOR carry out of MSB.
  - Results must be bit-identical to an unpipelined reference for every `STAGES`.
- Slicing: slice width is `SW = WIDTH/STAGES`.
  - Stage k adds bits `[k*SW +: SW]` using the carry registered by stage k-1. Stage 0 uses carry-in = `in_op`.
  - Unprocessed operand bits, already-computed result bits, op, and tag are carried forward in the stage register.
- Each stage holds one valid bit. A stage loads when it is empty, or when its contents advance in the same cycle (bubble-collapsing).
  - No entry is ever dropped or duplicated.
  - Order is strictly preserved.
- `in_ready` = stage 0 empty, or stage 0 advances this cycle. It is combinationally dependent on `out_ready` through the valid chain; this path is accepted.
- While `out_valid && !out_ready`, `out_sum`/`out_ovf`/`out_tag` are held stable.
- Capacity is `STAGES` operations in flight.

## Timing
- Reset (`rst` low): asynchronous.
  - All stage valids clear, so `out_valid`=0.
  - `out_sum`=0, `out_ovf`=0, `out_tag`=0, and all stage data registers = 0.
  - `in_ready` reads 1 on the first cycle after deassertion.
- Reset mid-stream: in-flight operations are discarded. No output beat appears for them after release.
- Latency: an operation accepted at edge N is presented with `out_valid`=1 after edge N+STAGES-1, i.e. visible in cycle N+STAGES. Assumes no downstream stall.
- Throughput: one operation per cycle while `out_ready`=1.
- Full pipeline with `out_ready`=0: `in_ready`=0.
  - Deasserting the stall frees stage 0 in the same cycle, so `in_ready` rises combinationally.
- Simultaneous accept and emit with all stages full: legal; occupancy stays at `STAGES`.
- Bubbles (gaps in `in_valid`) collapse when the output is stalled.
- `STAGES`=1: a single register stage, latency 1.

## Structure
- `adder_pkg` holds:
  - `typedef enum logic {OP_ADD, OP_SUB} op_e`;
  - the stage-record struct builder parameters;
  - a `function` reference model returning `{ovf, sum}`, shared by RTL assertions and the bench.
- Sub-module `addsub_slice` (parameter `SW`): combinational `SW`-bit adder with carry-in, carry-out and carry-into-MSB. It is instantiated `STAGES` times via `generate`.
- Top level contains the stage registers, the valid/advance chain, and the handshake logic.
- The bench interface is a successor to the existing adder interface:
  - adds `ready`, `op` and `tag` signals;
  - keeps a clocking block with 1 ns input/output skew.

## Test plan
Defaults WIDTH=16, STAGES=4, TAG_W=4 unless stated.
- ADD `0xFFFF`+`0x0001` → `out_sum`=`0x1_0000`, `out_ovf`=0; ADD `0x7FFF`+`0x0001` → `0x0_8000`, `out_ovf`=1; first `out_valid` 4 cycles after accept.
- SUB `0x0000`-`0x0001` → `out_sum`=`0x0_FFFF` (carry 0 = borrow), `out_ovf`=0; SUB `0x8000`-`0x0001` → `0x1_7FFF`, `out_ovf`=1.
- Backpressure: stream tags 0..9 back-to-back and hold `out_ready`=0 for 6 cycles.
  - Expect `in_ready` to fall after exactly 4 accepts and outputs to be held stable.
  - After release, tags emerge 0..9 in order with no gaps or repeats.
- Bubble collapse: inject with `in_valid` alternating 1/0 and `out_ready`=0.
  - Expect 4 operations accepted before `in_ready`=0.
- Reset mid-stream: assert `rst` low with 3 entries in flight.
  - Expect `out_valid`=0 immediately and all outputs zero.
  - After release, only newly injected tags appear.
- Random: 10k operations with random `out_ready`, swept over STAGES ∈ {1,2,4,8} and WIDTH ∈ {8,16,32}; all results match the `adder_pkg` model.
